// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// State encoding and stream-format constants.
package riscv_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_W          = 16;

  typedef enum logic [2:0] {
    LEN0  = 3'd0,
    LEN1  = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } ld_state_t;

endpackage

// File: rtl/word_assembler.sv
// Packs accepted bytes little-endian into a 32-bit word.
// word shows the lane merge combinationally so the completed word is usable on the 4th accept.
module word_assembler
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_byte,
  input  logic        accept,
  input  logic        clear,
  output logic [31:0] word,
  output logic        word_complete
);

  logic [1:0]  idx;
  logic [31:0] lanes;

  always_comb begin
    word = lanes;
    if (accept) begin
      word[{idx, 3'b000} +: 8] = data_byte;
    end
    word_complete = accept && (idx == 2'(BYTES_PER_WORD - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= '0;
      lanes <= '0;
    end else if (clear) begin
      idx   <= '0;
      lanes <= '0;
    end else if (accept) begin
      lanes <= word;
      idx   <= idx + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte stream -> sequential instruction-memory writes.
// Holds the core in reset until all words are written; one write cycle per 4 bytes.
module imem_loader
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              i_CLK,
  input  logic              i_Reset,
  input  logic [7:0]        i_Byte,
  input  logic              i_ByteValid,
  output logic              o_ByteReady,
  output logic              o_WE,
  output logic [ADDR_W-1:0] o_A,
  output logic [31:0]       o_WD,
  output logic              o_CoreReset,
  output logic              o_Done,
  output logic              o_Error
);

  ld_state_t         state, state_nxt;
  logic              started;
  logic [7:0]        n_lo;
  logic [LEN_W-1:0]  n_len;
  logic [LEN_W-1:0]  count;
  logic [ADDR_W-1:0] addr;
  logic              accept;
  logic              asm_accept;
  logic              asm_clear;
  logic [31:0]       asm_word;
  logic              word_complete;
  logic [LEN_W-1:0]  len_full;

  assign len_full = {i_Byte, n_lo};

  // started keeps ready low while reset is held and until the first edge after release
  assign o_ByteReady = started && (state == LEN0 || state == LEN1 || state == DATA);
  assign accept      = i_ByteValid && o_ByteReady;
  assign asm_accept  = accept && (state == DATA);
  assign o_Done      = (state == DONE);
  assign o_Error     = (state == ERROR);
  assign o_CoreReset = (state != DONE);

  word_assembler u_asm (
    .clk           (i_CLK),
    .rst           (i_Reset),
    .data_byte     (i_Byte),
    .accept        (asm_accept),
    .clear         (asm_clear),
    .word          (asm_word),
    .word_complete (word_complete)
  );

  always_comb begin
    state_nxt = state;
    asm_clear = 1'b0;
    case (state)
      LEN0: begin
        if (accept) state_nxt = LEN1;
      end
      LEN1: begin
        if (accept) begin
          if (len_full == '0) begin
            state_nxt = DONE;
          end else if ({1'b0, len_full} > 17'(DEPTH)) begin
            state_nxt = ERROR;
          end else begin
            state_nxt = DATA;
            asm_clear = 1'b1;
          end
        end
      end
      DATA: begin
        if (word_complete) state_nxt = WRITE;
      end
      WRITE: begin
        state_nxt = ((count + 16'd1) == n_len) ? DONE : DATA;
      end
      DONE:    state_nxt = DONE;
      ERROR:   state_nxt = ERROR;
      default: state_nxt = LEN0;
    endcase
  end

  always_ff @(posedge i_CLK or posedge i_Reset) begin
    if (i_Reset) begin
      state   <= LEN0;
      started <= 1'b0;
      n_lo    <= '0;
      n_len   <= '0;
      count   <= '0;
      addr    <= '0;
      o_WE    <= 1'b0;
      o_A     <= '0;
      o_WD    <= '0;
    end else begin
      state   <= state_nxt;
      started <= 1'b1;
      o_WE    <= (state_nxt == WRITE);
      if (state == LEN0 && accept) n_lo <= i_Byte;
      if (state == LEN1 && accept) n_len <= len_full;
      // capture address/data on entry to WRITE so they hold afterwards
      if (word_complete) begin
        o_A  <= addr;
        o_WD <= asm_word;
      end
      if (state == WRITE) begin
        addr  <= addr + 1'b1;
        count <= count + 16'd1;
      end
    end
  end

endmodule
